// File: rtl/div_mon_pkg.sv
// Shared types and default constants for the divided-clock period monitor.
// Optional min/max tracking is enabled with DIV_PERIOD_MON_MINMAX_EN.
package div_mon_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEAS
    } state_e;

    typedef enum logic [1:0] {
        NONE  = 2'b00,
        DIV_A = 2'b01,
        DIV_B = 2'b10,
        OTHER = 2'b11
    } ratio_e;

    localparam int RATIO_A_DEF    = 3;
    localparam int RATIO_B_DEF    = 6;
    localparam int LOCK_CNT_DEF   = 4;
    localparam int MAX_PERIOD_DEF = 63;

endpackage

// File: rtl/div_edge_det.sv
// Rising-edge detector for the divided signal, registered on clk.
module div_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic div_i,
    output logic rise_o
);

    logic div_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q <= 1'b0;
        end else begin
            div_q <= div_i;
        end
    end

    assign rise_o = div_i & ~div_q;

endmodule

// File: rtl/div_period_mon.sv
// Measures div rise-to-rise period, classifies the ratio, tracks lock and errors.
// Define DIV_PERIOD_MON_MINMAX_EN to add period_min / period_max outputs.
module div_period_mon
    import div_mon_pkg::*;
#(
    parameter int RATIO_A    = RATIO_A_DEF,
    parameter int RATIO_B    = RATIO_B_DEF,
    parameter int LOCK_CNT   = LOCK_CNT_DEF,
    parameter int MAX_PERIOD = MAX_PERIOD_DEF,
    parameter int CW         = $clog2(MAX_PERIOD + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          div,
    output logic [CW-1:0] period,
    output logic          period_vld,
    output logic [1:0]    ratio,
    output logic          lock,
    output logic          err
`ifdef DIV_PERIOD_MON_MINMAX_EN
    ,
    output logic [CW-1:0] period_min,
    output logic [CW-1:0] period_max
`endif
);

    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam logic [CW-1:0] RA = CW'(RATIO_A);
    localparam logic [CW-1:0] RB = CW'(RATIO_B);
    localparam logic [CW-1:0] MP = CW'(MAX_PERIOD);
    localparam logic [MW-1:0] LC = MW'(LOCK_CNT);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] prev_q, prev_d;
    logic [CW-1:0] period_q, period_d;
    logic [MW-1:0] match_q, match_d;
    ratio_e        ratio_q, ratio_d;
    logic          vld_q, vld_d;
    logic          lock_q, lock_d;
    logic          err_q, err_d;
    logic          rise;
`ifdef DIV_PERIOD_MON_MINMAX_EN
    logic [CW-1:0] min_q, min_d;
    logic [CW-1:0] max_q, max_d;
`endif

    div_edge_det u_edge (
        .clk   (clk),
        .rst   (rst),
        .div_i (div),
        .rise_o(rise)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            prev_q   <= '0;
            period_q <= '0;
            match_q  <= '0;
            ratio_q  <= NONE;
            vld_q    <= 1'b0;
            lock_q   <= 1'b0;
            err_q    <= 1'b0;
`ifdef DIV_PERIOD_MON_MINMAX_EN
            min_q    <= '1;
            max_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            prev_q   <= prev_d;
            period_q <= period_d;
            match_q  <= match_d;
            ratio_q  <= ratio_d;
            vld_q    <= vld_d;
            lock_q   <= lock_d;
            err_q    <= err_d;
`ifdef DIV_PERIOD_MON_MINMAX_EN
            min_q    <= min_d;
            max_q    <= max_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        prev_d   = prev_q;
        period_d = period_q;
        match_d  = match_q;
        ratio_d  = ratio_q;
        vld_d    = 1'b0;
        lock_d   = lock_q;
        err_d    = err_q;
`ifdef DIV_PERIOD_MON_MINMAX_EN
        min_d    = min_q;
        max_d    = max_q;
`endif
        if (!en) begin
            state_d = IDLE;
            cnt_d   = '0;
            match_d = '0;
            prev_d  = '0;
            lock_d  = 1'b0;
            err_d   = 1'b0;
            ratio_d = NONE;
`ifdef DIV_PERIOD_MON_MINMAX_EN
            min_d   = '1;
            max_d   = '0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = ARM;
                    prev_d  = '0;
                end
                ARM: begin
                    if (rise) begin
                        cnt_d   = CW'(1);
                        state_d = MEAS;
                    end
                end
                MEAS: begin
                    if (rise) begin
                        cnt_d    = CW'(1);
                        prev_d   = cnt_q;
                        period_d = cnt_q;
                        vld_d    = 1'b1;
                        if (cnt_q == RA) begin
                            ratio_d = DIV_A;
                        end else if (cnt_q == RB) begin
                            ratio_d = DIV_B;
                        end else begin
                            ratio_d = OTHER;
                        end
                        // prev is 0 after ARM, so the first period never matches
                        if (cnt_q == prev_q) begin
                            if (match_q != LC) begin
                                match_d = match_q + 1'b1;
                            end
                            if (match_d == LC) begin
                                lock_d = 1'b1;
                            end
                        end else begin
                            match_d = '0;
                            lock_d  = 1'b0;
                            if (lock_q) begin
                                err_d = 1'b1;
                            end
                        end
`ifdef DIV_PERIOD_MON_MINMAX_EN
                        if (cnt_q < min_q) begin
                            min_d = cnt_q;
                        end
                        if (cnt_q > max_q) begin
                            max_d = cnt_q;
                        end
`endif
                    end else if (cnt_q == MP) begin
                        err_d   = 1'b1;
                        lock_d  = 1'b0;
                        match_d = '0;
                        ratio_d = NONE;
                        prev_d  = '0;
                        cnt_d   = '0;
                        state_d = ARM;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign period     = period_q;
    assign period_vld = vld_q;
    assign ratio      = ratio_q;
    assign lock       = lock_q;
    assign err        = err_q;
`ifdef DIV_PERIOD_MON_MINMAX_EN
    assign period_min = min_q;
    assign period_max = max_q;
`endif

endmodule

// File: tb/tb_div_period_mon.sv
// Randomized self-checking bench for div_period_mon against a timestamp-based model.
// Also checks period_min/period_max when DIV_PERIOD_MON_MINMAX_EN is defined.
module tb_div_period_mon;

    localparam int CW = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en  = 1'b0;
    logic          div = 1'b0;
    logic [CW-1:0] period;
    logic          period_vld;
    logic [1:0]    ratio;
    logic          lock;
    logic          err;
`ifdef DIV_PERIOD_MON_MINMAX_EN
    logic [CW-1:0] period_min;
    logic [CW-1:0] period_max;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    div_period_mon dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .div       (div),
        .period    (period),
        .period_vld(period_vld),
        .ratio     (ratio),
        .lock      (lock),
        .err       (err)
`ifdef DIV_PERIOD_MON_MINMAX_EN
        ,
        .period_min(period_min),
        .period_max(period_max)
`endif
    );

    // Model: phase 0 idle, 1 armed, 2 measuring; periods from rise timestamps
    int phase, cyc, t_last, last_per, streak;
    bit m_divq;
    int e_period, e_vld, e_ratio, e_lock, e_err, e_min, e_max;

    task automatic check(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        phase = 0; m_divq = 0; last_per = 0; streak = 0;
        e_period = 0; e_vld = 0; e_ratio = 0; e_lock = 0; e_err = 0;
        e_min = 63; e_max = 0;
    endtask

    task automatic model_step();
        bit rise;
        int p;
        rise = div && !m_divq;
        m_divq = div;
        cyc++;
        e_vld = 0;
        if (!en) begin
            phase = 0; last_per = 0; streak = 0;
            e_lock = 0; e_err = 0; e_ratio = 0; e_min = 63; e_max = 0;
        end else if (phase == 0) begin
            phase = 1; last_per = 0;
        end else if (phase == 1) begin
            if (rise) begin
                phase = 2; t_last = cyc;
            end
        end else if (rise) begin
            p = cyc - t_last;
            t_last = cyc;
            e_period = p;
            e_vld = 1;
            e_ratio = (p == 3) ? 1 : (p == 6) ? 2 : 3;
            if (p == last_per) begin
                streak = (streak < 4) ? streak + 1 : 4;
                if (streak == 4) e_lock = 1;
            end else begin
                streak = 0;
                if (e_lock != 0) e_err = 1;
                e_lock = 0;
            end
            last_per = p;
            if (p < e_min) e_min = p;
            if (p > e_max) e_max = p;
        end else if (cyc - t_last == 63) begin
            e_err = 1; e_lock = 0; streak = 0; e_ratio = 0;
            phase = 1; last_per = 0;
        end
    endtask

    initial begin
        cyc = 0;
        t_last = 0;
        model_reset();
        forever begin
            @(negedge clk);
            if (!rst) model_reset();
            else model_step();
            check("period", int'(period), e_period);
            check("period_vld", int'(period_vld), e_vld);
            check("ratio", int'(ratio), e_ratio);
            check("lock", int'(lock), e_lock);
            check("err", int'(err), e_err);
`ifdef DIV_PERIOD_MON_MINMAX_EN
            check("period_min", int'(period_min), e_min);
            check("period_max", int'(period_max), e_max);
`endif
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic gen(int p, int hi, int n);
        for (int k = 0; k < n; k++) begin
            for (int i = 0; i < p; i++) begin
                div = (i < hi);
                tick();
            end
        end
    endtask

    initial begin
        repeat (3) tick();
        check("rst_period", int'(period), 0);
        check("rst_lock", int'(lock), 0);
        check("rst_err", int'(err), 0);
        rst = 1'b1;
        tick();

        en = 1'b1;
        gen(3, 1, 8);
        check("t1_period", int'(period), 3);
        check("t1_ratio", int'(ratio), 1);
        check("t1_lock", int'(lock), 1);
        check("t1_err", int'(err), 0);

        gen(6, 3, 2);
        check("t3_period", int'(period), 6);
        check("t3_ratio", int'(ratio), 2);
        check("t3_lock", int'(lock), 0);
        check("t3_err", int'(err), 1);
        gen(6, 3, 5);
        check("t3_relock", int'(lock), 1);
        check("t3_err_sticky", int'(err), 1);

        gen(3, 1, 8);
        check("t4_prelock", int'(lock), 1);
        div = 1'b0;
        repeat (70) tick();
        check("t4_err", int'(err), 1);
        check("t4_lock", int'(lock), 0);
        check("t4_ratio", int'(ratio), 0);
        check("t4_period", int'(period), 3);
        gen(3, 1, 3);
        check("t4_restart", int'(period), 3);

        en = 1'b0;
        div = 1'b0;
        tick();
        check("t5_err", int'(err), 0);
        check("t5_lock", int'(lock), 0);
        check("t5_ratio", int'(ratio), 0);
        check("t5_period", int'(period), 3);
        en = 1'b1;
        gen(3, 1, 4);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("t5_rst_period", int'(period), 0);
        check("t5_rst_vld", int'(period_vld), 0);
        check("t5_rst_ratio", int'(ratio), 0);
        check("t5_rst_lock", int'(lock), 0);
        tick();
        rst = 1'b1;

        gen(6, 3, 8);
        check("t2_period", int'(period), 6);
        check("t2_ratio", int'(ratio), 2);
        check("t2_lock", int'(lock), 1);
        check("t2_err", int'(err), 0);

        en = 1'b0;
        tick();
`ifdef DIV_PERIOD_MON_MINMAX_EN
        check("t6_min_clr", int'(period_min), 63);
        check("t6_max_clr", int'(period_max), 0);
`endif
        en = 1'b1;
        gen(3, 1, 3);
        gen(6, 3, 1);
        gen(5, 2, 1);
        div = 1'b1;
        tick();
        div = 1'b0;
        tick();
        check("t6_period", int'(period), 5);
        check("t6_ratio", int'(ratio), 3);
`ifdef DIV_PERIOD_MON_MINMAX_EN
        check("t6_min", int'(period_min), 3);
        check("t6_max", int'(period_max), 6);
`endif

        for (int s = 0; s < 40; s++) begin
            int r, p, hi;
            r = $urandom_range(0, 9);
            if (r <= 5) begin
                case ($urandom_range(0, 3))
                    0: p = 3;
                    1: p = 6;
                    2: p = 5;
                    default: p = $urandom_range(2, 12);
                endcase
                hi = $urandom_range(1, p - 1);
                gen(p, hi, $urandom_range(2, 8));
            end else if (r == 6) begin
                div = 1'b0;
                repeat ($urandom_range(55, 70)) tick();
            end else if (r == 7) begin
                div = 1'b1;
                repeat ($urandom_range(60, 70)) tick();
            end else if (r == 8) begin
                en = 1'b0;
                repeat ($urandom_range(1, 3)) tick();
                en = 1'b1;
            end else begin
                repeat (20) begin
                    div = 1'($urandom_range(0, 1));
                    tick();
                end
            end
        end

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_period_mon.md
Name: div_period_mon

Overview:
- Receive-side monitor for the divided output `div` of the clock-divider counter.
- Measures the interval between consecutive rising edges of `div` in `clk` cycles.
- Classifies the interval as divide-by-3, divide-by-6 or other, and declares lock after repeated identical periods.
- Flags errors on period change while locked, and on timeout.
- Sits beside the divider in the HLDD lab and serves as the self-checking counterpart.

Parameters:
- RATIO_A, 3, first expected division ratio (clk cycles per div period).
- RATIO_B, 6, second expected division ratio.
- LOCK_CNT, 4, consecutive equal periods required to assert lock.
- MAX_PERIOD, 63, maximum count without a div rising edge before timeout.
- CW, $clog2(MAX_PERIOD+1), counter/period width (derived; do not override).

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  asynchronous active-low reset.
- en  input  1  monitor enable; low holds the monitor idle.
- div  input  1  divided signal, synchronous to clk.
- period  output  CW  last measured period in clk cycles.
- period_vld  output  1  single-cycle pulse when `period` updates.
- ratio  output  2  00 NONE, 01 DIV_A, 10 DIV_B, 11 OTHER.
- lock  output  1  high after LOCK_CNT consecutive equal periods.
- err  output  1  sticky error flag.

Behaviour:
- Reset (rst=0, async): state=IDLE; div_q=0, cnt=0, match_cnt=0, prev=0; period=0, period_vld=0, ratio=NONE, lock=0, err=0.
- Edge detect: rise = div & ~div_q, where div_q is `div` registered each cycle in every state.
- States:
  - IDLE: en=1 -> ARM next cycle.
  - ARM: on rise -> cnt<=1, go MEAS.
  - MEAS: counts cycles between rises.
- MEAS, no rise: cnt<=cnt+1. If cnt==MAX_PERIOD: timeout.
- MEAS, rise: period<=cnt, period_vld=1 in the following cycle (latency 1 from the rise-sampling edge), cnt<=1, prev<=cnt.
- MEAS, rise, ratio update (same register update as period): cnt==RATIO_A -> DIV_A; cnt==RATIO_B -> DIV_B; else OTHER.
- Match logic on each rise in MEAS:
  - cnt==prev: match_cnt increments, saturating at LOCK_CNT; lock=1 when match_cnt reaches LOCK_CNT.
  - cnt!=prev: match_cnt<=0; if lock was 1 then lock<=0 and err<=1.
  - The first measured period after ARM never matches; prev is cleared on entry to ARM.
- Timeout: err<=1, lock<=0, match_cnt<=0, ratio<=NONE, period holds, go ARM. No period_vld is generated.
- en=0 in any state -> IDLE next cycle. Clears cnt, match_cnt, prev, lock, err and ratio; period holds. en takes priority over a simultaneous rise or timeout.
- err is sticky: cleared only by reset or by en=0.
- div held high continuously produces no rise and therefore times out.
- Reset mid-measurement discards all progress.

Optional Feature:
- Macro: DIV_PERIOD_MON_MINMAX_EN.
- Defined:
  - Adds outputs period_min and period_max (CW each), updated on every period_vld.
  - Reset and en=0 set period_min to all-ones and period_max to 0.
  - Timeout leaves both unchanged.
- Undefined: the ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package div_mon_pkg:
  - state_e {IDLE, ARM, MEAS}.
  - ratio_e {NONE=2'b00, DIV_A=2'b01, DIV_B=2'b10, OTHER=2'b11}.
  - Default constants for RATIO_A, RATIO_B, LOCK_CNT, MAX_PERIOD.
- Sub-module div_edge_det:
  - Registers div and outputs the rise pulse.
  - Uses the same clk and rst, and resets to 0.

Test Plan:
1. Reset and enable: reset, en=1, div high 1 of every 3 clk cycles -> first period_vld one cycle after the 2nd rise; period=3, ratio=01; lock=1 on the 5th measured period (LOCK_CNT=4); err=0.
2. Divide-by-6: div high 3 of 6 cycles -> period=6, ratio=10, lock after 5 periods.
3. Ratio switch while locked: locked at 3, div switches to a 6-cycle period -> at the first 6 measurement lock=0, err=1, ratio=10; relock after 4 more matches while err stays 1.
4. Timeout: locked, then div held at 0 -> 63 cycles after the last rise err=1, lock=0, ratio=00, period=3 held; the next rise restarts measurement.
5. Enable and reset clearing: en pulsed low for 1 cycle while err=1 -> err=0, lock=0, ratio=00, period holds; rst asserted mid-MEAS -> all outputs 0 asynchronously.
6. Odd period (with DIV_PERIOD_MON_MINMAX_EN): periods 3, 6, 5 -> ratio=11 on the 5; period_min=3, period_max=6.
